// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types and constants.
// Exports XLEN, PC_STEP, NOP_ENC and the fetch_entry_t {pc, instr} bundle.
package instruction_fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] NOP_ENC = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_buffer.sv
// Two-entry FIFO of fetch entries between imem responses and decode.
// Ports: push_i/push_data_i in, pop_i out, flush_i clears, count_o/head_o status.
module instruction_fetch_buffer
    import instruction_fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    // A push into a full buffer is only legal when the head leaves this cycle.
    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues imem word reads, queues results for decode.
// Ports: redirect_i/redirect_pc_i, imem req/gnt/rvalid, decode valid_o/ready_i.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR    = NOP_ENC
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            ready_i
);

    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            outstanding_q;
    logic            drop_q;
    logic [1:0]      count;
    logic [2:0]      count_next;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            rsp;
    logic            push;
    logic            pop;
    logic            grant;
    logic            out_after;
    logic            unused_pc_bits;

    // rvalid with nothing outstanding is stale and ignored.
    assign rsp       = imem_rvalid_i && outstanding_q;
    assign out_after = outstanding_q && !imem_rvalid_i;
    assign push      = rsp && !drop_q && !redirect_i;
    assign pop       = valid_o && ready_i && !redirect_i;

    // Issue only when the new word is guaranteed a slot: the queue
    // occupancy after this cycle's push/pop must leave one free entry.
    assign count_next = {1'b0, count} + {2'b00, push} - {2'b00, pop};
    assign imem_req_o = !rst_i && !redirect_i && !out_after
                        && (count_next < 3'd2);
    assign imem_addr_o = fetch_pc_q;
    assign grant       = imem_req_o && imem_gnt_i;

    assign push_entry = '{pc: req_pc_q, instr: imem_rdata_i};
    assign unused_pc_bits = ^redirect_pc_i[1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_VECTOR;
            req_pc_q      <= RESET_VECTOR;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
        end else if (redirect_i) begin
            fetch_pc_q    <= {redirect_pc_i[XLEN-1:2], 2'b00};
            outstanding_q <= out_after;
            // A request still in flight belongs to the old path.
            drop_q        <= out_after;
        end else begin
            if (grant) begin
                fetch_pc_q <= fetch_pc_q + PC_STEP;
                req_pc_q   <= fetch_pc_q;
            end
            outstanding_q <= grant || out_after;
            if (rsp) drop_q <= 1'b0;
        end
    end

    instruction_fetch_buffer u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (redirect_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .count_o     (count),
        .head_o      (head)
    );

    assign valid_o = (count != 2'd0);
    assign instr_o = valid_o ? head.instr : NOP_INSTR;
    assign pc_o    = valid_o ? head.pc : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch.
// Drives the imem/decode sides cycle by cycle and checks against hand values.
module tb_instruction_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b1;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        ready_i = 1'b1;

    int          vec = 0;
    int          errs = 0;
    bit          auto_rsp = 1'b1;
    logic        g_pend;
    logic [31:0] a_pend;

    always #5 clk_i = ~clk_i;

    instruction_fetch dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .ready_i       (ready_i)
    );

    // Memory responder: data = addr ^ A5A5_0000, one cycle after grant.
    initial begin
        g_pend = 1'b0;
        a_pend = 32'h0;
        forever begin
            @(negedge clk_i);
            g_pend = auto_rsp && imem_req_o && imem_gnt_i && !rst_i;
            a_pend = imem_addr_o;
            @(posedge clk_i);
            #1;
            if (auto_rsp) begin
                imem_rvalid_i = g_pend;
                imem_rdata_i  = g_pend ? (a_pend ^ 32'hA5A5_0000) : 32'h0;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    // Leaves the bench at the start of cycle 0 after reset release.
    task automatic do_reset(input bit auto);
        rst_i = 1'b1;
        redirect_i = 1'b0;
        auto_rsp = auto;
        tick();
        imem_rvalid_i = 1'b0;
        imem_rdata_i = 32'h0;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vec++; if (imem_req_o !== 1'b0) begin errs++;
            $display("FAIL rst_req got %b want 0", imem_req_o); end
        vec++; if (imem_addr_o !== 32'h0) begin errs++;
            $display("FAIL rst_addr got %h want 0", imem_addr_o); end
        vec++; if (valid_o !== 1'b0) begin errs++;
            $display("FAIL rst_valid got %b want 0", valid_o); end
        vec++; if (instr_o !== 32'h0000_0013) begin errs++;
            $display("FAIL rst_instr got %h want 00000013", instr_o); end
        vec++; if (pc_o !== 32'h0) begin errs++;
            $display("FAIL rst_pc got %h want 0", pc_o); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        imem_gnt_i = 1'b1;
        ready_i = 1'b1;
        do_reset(1'b1);
        settle();
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errs++;
            $display("FAIL stream_c0 req %b addr %h want 1 0", imem_req_o, imem_addr_o); end
        for (int c = 1; c <= 5; c++) begin
            tick();
            settle();
            if (c < 2) begin
                vec++; if (valid_o !== 1'b0) begin errs++;
                    $display("FAIL stream_c%0d valid %b want 0", c, valid_o); end
                vec++; if (imem_addr_o !== 32'h4) begin errs++;
                    $display("FAIL stream_c%0d addr %h want 4", c, imem_addr_o); end
            end else begin
                exp_pc = 32'(4 * (c - 2));
                vec++; if (valid_o !== 1'b1 || pc_o !== exp_pc) begin errs++;
                    $display("FAIL stream_c%0d valid %b pc %h want 1 %h", c, valid_o, pc_o, exp_pc); end
                vec++; if (instr_o !== (exp_pc ^ 32'hA5A5_0000)) begin errs++;
                    $display("FAIL stream_c%0d instr %h want %h", c, instr_o, exp_pc ^ 32'hA5A5_0000); end
            end
        end
    endtask

    // Continues from test_stream at cycle 6.
    task automatic test_stall();
        logic [31:0] exp_pc;
        for (int c = 6; c <= 11; c++) begin
            tick();
            ready_i = 1'b0;
            settle();
            vec++; if (imem_req_o !== 1'b0) begin errs++;
                $display("FAIL stall_c%0d req %b want 0", c, imem_req_o); end
            vec++; if (valid_o !== 1'b1 || pc_o !== 32'h10 || instr_o !== 32'hA5A5_0010) begin errs++;
                $display("FAIL stall_c%0d valid %b pc %h instr %h want 1 10 a5a50010", c, valid_o, pc_o, instr_o); end
        end
        for (int c = 12; c <= 15; c++) begin
            tick();
            ready_i = 1'b1;
            settle();
            exp_pc = 32'h10 + 32'(4 * (c - 12));
            if (c == 12) begin
                vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h18) begin errs++;
                    $display("FAIL resume_req req %b addr %h want 1 18", imem_req_o, imem_addr_o); end
            end
            vec++; if (valid_o !== 1'b1 || pc_o !== exp_pc) begin errs++;
                $display("FAIL resume_c%0d valid %b pc %h want 1 %h", c, valid_o, pc_o, exp_pc); end
        end
    endtask

    task automatic test_gnt_delay();
        imem_gnt_i = 1'b1;
        ready_i = 1'b1;
        do_reset(1'b1);
        tick();
        imem_gnt_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) imem_gnt_i = 1'b1;
            settle();
            vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin errs++;
                $display("FAIL gnt_wait_c%0d req %b addr %h want 1 4", c, imem_req_o, imem_addr_o); end
            tick();
        end
        settle();
        vec++; if (valid_o !== 1'b0) begin errs++;
            $display("FAIL gnt_c5 valid %b want 0", valid_o); end
        tick();
        settle();
        vec++; if (valid_o !== 1'b1 || pc_o !== 32'h4 || instr_o !== 32'hA5A5_0004) begin errs++;
            $display("FAIL gnt_c6 valid %b pc %h instr %h want 1 4 a5a50004", valid_o, pc_o, instr_o); end
    endtask

    task automatic test_redirect_outstanding();
        imem_gnt_i = 1'b1;
        ready_i = 1'b1;
        do_reset(1'b0);
        settle();
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errs++;
            $display("FAIL rdo_c0 req %b addr %h want 1 0", imem_req_o, imem_addr_o); end
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        settle();
        vec++; if (imem_req_o !== 1'b0) begin errs++;
            $display("FAIL rdo_c1 req %b want 0", imem_req_o); end
        tick();
        redirect_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        settle();
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin errs++;
            $display("FAIL rdo_c2 req %b addr %h want 1 100", imem_req_o, imem_addr_o); end
        vec++; if (valid_o !== 1'b0) begin errs++;
            $display("FAIL rdo_c2 valid %b want 0", valid_o); end
        tick();
        imem_rdata_i = 32'h0010_0093;
        settle();
        vec++; if (valid_o !== 1'b0) begin errs++;
            $display("FAIL rdo_c3 valid %b want 0", valid_o); end
        tick();
        imem_rvalid_i = 1'b0;
        ready_i = 1'b0;
        settle();
        vec++; if (valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== 32'h0010_0093) begin errs++;
            $display("FAIL rdo_c4 valid %b pc %h instr %h want 1 100 00100093", valid_o, pc_o, instr_o); end
    endtask

    // Continues from test_redirect_outstanding: 0x104 is still in flight.
    task automatic test_reset_midwait();
        tick();
        settle();
        vec++; if (valid_o !== 1'b1 || pc_o !== 32'h100) begin errs++;
            $display("FAIL mid_pre valid %b pc %h want 1 100", valid_o, pc_o); end
        #2;
        rst_i = 1'b1;
        #1;
        vec++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0) begin errs++;
            $display("FAIL mid_rst req %b addr %h want 0 0", imem_req_o, imem_addr_o); end
        vec++; if (valid_o !== 1'b0 || instr_o !== 32'h13 || pc_o !== 32'h0) begin errs++;
            $display("FAIL mid_rst valid %b instr %h pc %h want 0 13 0", valid_o, instr_o, pc_o); end
        tick();
        tick();
        rst_i = 1'b0;
        imem_gnt_i = 1'b0;
        ready_i = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'hBAD0_BAD0;
        settle();
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errs++;
            $display("FAIL mid_a req %b addr %h want 1 0", imem_req_o, imem_addr_o); end
        tick();
        imem_rvalid_i = 1'b0;
        imem_gnt_i = 1'b1;
        settle();
        vec++; if (valid_o !== 1'b0) begin errs++;
            $display("FAIL mid_stale valid %b pc %h want 0", valid_o, pc_o); end
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errs++;
            $display("FAIL mid_b req %b addr %h want 1 0", imem_req_o, imem_addr_o); end
        tick();
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h1111_1111;
        settle();
        vec++; if (valid_o !== 1'b0) begin errs++;
            $display("FAIL mid_c valid %b want 0", valid_o); end
        tick();
        imem_rvalid_i = 1'b0;
        settle();
        vec++; if (valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'h1111_1111) begin errs++;
            $display("FAIL mid_d valid %b pc %h instr %h want 1 0 11111111", valid_o, pc_o, instr_o); end
    endtask

    task automatic test_redirect_rvalid();
        imem_gnt_i = 1'b1;
        ready_i = 1'b0;
        do_reset(1'b1);
        tick();
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        settle();
        vec++; if (valid_o !== 1'b1 || pc_o !== 32'h0 || imem_req_o !== 1'b0) begin errs++;
            $display("FAIL rdv_c2 valid %b pc %h req %b want 1 0 0", valid_o, pc_o, imem_req_o); end
        tick();
        redirect_i = 1'b0;
        settle();
        vec++; if (valid_o !== 1'b0) begin errs++;
            $display("FAIL rdv_c3 valid %b want 0", valid_o); end
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin errs++;
            $display("FAIL rdv_c3 req %b addr %h want 1 200", imem_req_o, imem_addr_o); end
        tick();
        settle();
        vec++; if (valid_o !== 1'b0) begin errs++;
            $display("FAIL rdv_c4 valid %b pc %h want 0", valid_o, pc_o); end
        tick();
        settle();
        vec++; if (valid_o !== 1'b1 || pc_o !== 32'h200 || instr_o !== 32'hA5A5_0200) begin errs++;
            $display("FAIL rdv_c5 valid %b pc %h instr %h want 1 200 a5a50200", valid_o, pc_o, instr_o); end
    endtask

    task automatic test_wrap();
        imem_gnt_i = 1'b1;
        ready_i = 1'b1;
        do_reset(1'b1);
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        settle();
        vec++; if (imem_req_o !== 1'b0) begin errs++;
            $display("FAIL wrap_c1 req %b want 0", imem_req_o); end
        tick();
        redirect_i = 1'b0;
        settle();
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin errs++;
            $display("FAIL wrap_c2 req %b addr %h want 1 fffffffc", imem_req_o, imem_addr_o); end
        tick();
        settle();
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errs++;
            $display("FAIL wrap_c3 req %b addr %h want 1 0", imem_req_o, imem_addr_o); end
        tick();
        settle();
        vec++; if (valid_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC || instr_o !== 32'h5A5A_FFFC) begin errs++;
            $display("FAIL wrap_c4 valid %b pc %h instr %h want 1 fffffffc 5a5afffc", valid_o, pc_o, instr_o); end
        tick();
        settle();
        vec++; if (valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'hA5A5_0000) begin errs++;
            $display("FAIL wrap_c5 valid %b pc %h instr %h want 1 0 a5a50000", valid_o, pc_o, instr_o); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_gnt_delay();
        test_redirect_outstanding();
        test_reset_midwait();
        test_redirect_rvalid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
